// File: rtl/sender_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : sender_wrapper
// Brief    : URLLC transmit path - samples ADC words, frames them and emits
//            an oversampled 2-level waveform on the DAC bus.
// Revision : 1.0 - initial release
// ============================================================================
module sender_wrapper #(
    parameter int         SAMPLE_PERIOD = 128,
    parameter int         SPB           = 8,
    parameter int         PAYLOAD_BYTES = 4,
    parameter logic [7:0] PREAMBLE      = 8'hAA,
    parameter logic [7:0] SYNC_WORD     = 8'h7E,
    parameter logic [7:0] LEVEL_HI      = 8'hFF,
    parameter logic [7:0] LEVEL_LO      = 8'h00,
    parameter logic [7:0] LEVEL_IDLE    = 8'h80
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sender_sync_in,
    output logic       sender_sync_out,
    input  logic [7:0] sender_ad,
    output logic [7:0] sender_da
);

    localparam int BUF_W       = 8 * PAYLOAD_BYTES;
    localparam int FRAME_BITS  = 8 * (PAYLOAD_BYTES + 4);
    localparam int SCNT_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CYC_W       = (SPB > 1) ? $clog2(SPB) : 1;
    localparam int BIT_W       = $clog2(FRAME_BITS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              ad_q, ad_d;
    logic [SCNT_W-1:0]       scnt_q, scnt_d;
    logic [BUF_W-1:0]        buf_q, buf_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [7:0]              da_q, da_d;
    logic                    sync_q, sync_d;

    logic [7:0]              chk;
    logic [FRAME_BITS-1:0]   snapshot;
    logic                    frame_end;
    logic                    start_frame;

    // Sampler: free-running, independent of the transmit state
    always_comb begin
        ad_d   = sender_ad;
        scnt_d = scnt_q + 1'b1;
        buf_d  = buf_q;
        if (scnt_q == SCNT_W'(SAMPLE_PERIOD - 1)) begin
            scnt_d = '0;
            buf_d  = {buf_q[BUF_W-9:0], ad_q};
        end
    end

    always_comb begin
        chk = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            chk = chk + buf_q[i*8 +: 8];
        end
        snapshot = {PREAMBLE, PREAMBLE, SYNC_WORD, buf_q, chk};
    end

    assign frame_end   = (bit_q == BIT_W'(FRAME_BITS - 1)) && (cyc_q == CYC_W'(SPB - 1));
    assign start_frame = sender_sync_in && ((state_q == ST_IDLE) || frame_end);

    // Transmit FSM; the frame MSB always drives the DAC level while sending
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        sync_d  = 1'b0;
        da_d    = LEVEL_IDLE;
        if (start_frame) begin
            state_d = ST_SEND;
            frame_d = snapshot;
            cyc_d   = '0;
            bit_d   = '0;
            sync_d  = 1'b1;
        end else if (state_q == ST_SEND) begin
            if (frame_end) begin
                state_d = ST_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end else if (cyc_q == CYC_W'(SPB - 1)) begin
                cyc_d   = '0;
                bit_d   = bit_q + 1'b1;
                frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
            end else begin
                cyc_d   = cyc_q + 1'b1;
            end
        end
        if (state_d == ST_SEND) begin
            da_d = frame_d[FRAME_BITS-1] ? LEVEL_HI : LEVEL_LO;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ad_q    <= '0;
            scnt_q  <= '0;
            buf_q   <= '0;
            frame_q <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
            da_q    <= LEVEL_IDLE;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ad_q    <= ad_d;
            scnt_q  <= scnt_d;
            buf_q   <= buf_d;
            frame_q <= frame_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            da_q    <= da_d;
            sync_q  <= sync_d;
        end
    end

    assign sender_da       = da_q;
    assign sender_sync_out = sync_q;

endmodule
`default_nettype wire

// File: tb/tb_sender_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_sender_wrapper
// Brief    : Directed self-checking bench for sender_wrapper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sender_wrapper;

    logic       clock;
    logic       reset;
    logic       sender_sync_in;
    logic       sender_sync_out;
    logic [7:0] sender_ad;
    logic [7:0] sender_da;

    int errors = 0;
    int checks = 0;
    bit stepping = 0;
    int step_cnt = 0;

    // Reference sampler: buffer of last four captures, oldest in the top byte
    logic [6:0]  m_cnt;
    logic [7:0]  m_adq;
    logic [31:0] m_buf;
    logic [31:0] m_prev;

    sender_wrapper dut (
        .clock           (clock),
        .reset           (reset),
        .sender_sync_in  (sender_sync_in),
        .sender_sync_out (sender_sync_out),
        .sender_ad       (sender_ad),
        .sender_da       (sender_da)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        m_prev <= m_buf;
        if (reset) begin
            m_cnt <= 7'd0;
            m_adq <= 8'h00;
            m_buf <= 32'h0;
        end else begin
            m_cnt <= m_cnt + 7'd1;
            m_adq <= sender_ad;
            if (m_cnt == 7'd127) m_buf <= {m_buf[23:0], m_adq};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (stepping) begin
            step_cnt++;
            if (step_cnt == 360) begin
                step_cnt  = 0;
                sender_ad = sender_ad + 8'd1;
            end
        end
    endtask

    task automatic wait_sync(input string tag, input int max_cyc);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!sender_sync_out && n < max_cyc);
        check({tag, "_sync"}, 32'(sender_sync_out), 32'd1);
        check({tag, "_lat"}, n, 32'd1);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (sender_da !== 8'h80 || sender_sync_out !== 1'b0) bad++;
        end
        check(tag, bad, 32'd0);
    endtask

    // Called with the k=0 cycle already sampled; checks every frame cycle
    task automatic run_frame(input string tag, input int drop_at, input int rst_at,
                             output logic [63:0] obs);
        logic [63:0] exp;
        logic [7:0]  chk;
        logic        bitv;
        int          bad;
        bit          aborted;
        chk = m_prev[31:24] + m_prev[23:16] + m_prev[15:8] + m_prev[7:0];
        exp = {8'hAA, 8'hAA, 8'h7E, m_prev, chk};
        obs = '0;
        bad = 0;
        aborted = 0;
        for (int k = 0; k < 512; k++) begin
            if (k > 0) step();
            if (sender_sync_out !== (k == 0)) bad++;
            bitv = (sender_da === 8'hFF);
            if (sender_da !== 8'hFF && sender_da !== 8'h00) bad++;
            if (k % 8 == 0) obs[63 - k/8] = bitv;
            else if (obs[63 - k/8] !== bitv) bad++;
            if (k == drop_at) sender_sync_in = 1'b0;
            if (k == rst_at) begin
                reset   = 1'b1;
                aborted = 1;
                break;
            end
        end
        check({tag, "_shape"}, bad, 32'd0);
        if (!aborted) begin
            for (int b = 0; b < 8; b++) begin
                check($sformatf("%s_byte%0d", tag, b), 32'(obs[63-8*b -: 8]), 32'(exp[63-8*b -: 8]));
            end
        end
    endtask

    initial begin
        logic [63:0] obs;
        reset          = 1'b1;
        sender_sync_in = 1'b0;
        sender_ad      = 8'h20;

        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_da%0d", i), 32'(sender_da), 32'h80);
            check($sformatf("rst_sync%0d", i), 32'(sender_sync_out), 32'd0);
        end

        // Idle long enough to fill the buffer with 0x20
        reset = 1'b0;
        idle_check("idle_nosync", 600);

        sender_sync_in = 1'b1;
        wait_sync("f1", 4);
        run_frame("f1", -1, -1, obs);
        check("f1_pre", 32'(obs[63:48]), 32'hAAAA);
        check("f1_sw", 32'(obs[47:40]), 32'h7E);
        check("f1_payload", obs[39:8], 32'h20202020);
        check("f1_chk", 32'(obs[7:0]), 32'h80);

        wait_sync("f2", 4);
        run_frame("f2", -1, -1, obs);
        check("f2_chk", 32'(obs[7:0]), 32'h80);

        // Stepping samples; back-to-back frames track the last four captures
        stepping = 1;
        wait_sync("f3", 4);
        run_frame("f3", -1, -1, obs);
        wait_sync("f4", 4);
        run_frame("f4", -1, -1, obs);
        wait_sync("f5", 4);
        run_frame("f5", 100, -1, obs);
        stepping = 0;
        idle_check("idle_after_drop", 600);

        // Reset mid-frame, then restart with an empty buffer
        sender_sync_in = 1'b1;
        wait_sync("f6", 4);
        run_frame("f6", -1, 300, obs);
        step();
        check("abort_da", 32'(sender_da), 32'h80);
        check("abort_sync", 32'(sender_sync_out), 32'd0);
        step();
        step();
        reset = 1'b0;
        wait_sync("f7", 4);
        run_frame("f7", 0, -1, obs);
        check("f7_payload", obs[39:8], 32'h0);
        check("f7_chk", 32'(obs[7:0]), 32'h0);
        idle_check("idle_end", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sender_wrapper.md
Name: sender_wrapper

Overview:
- Top-level transmit block of the URLLC sender path: samples an 8-bit ADC word stream, packs samples into fixed-length frames and emits them as a 2-level, oversampled baseband waveform on an 8-bit DAC bus.
- Frame start is marked by a one-cycle sync pulse for downstream alignment.
- Sits between the board ADC/DAC pins and is enabled by an external sync/enable line.

Parameters:
- SAMPLE_PERIOD, 128: clock cycles between ADC captures.
- SPB, 8: clock cycles each bit is held on the DAC (samples per bit).
- PAYLOAD_BYTES, 4: ADC samples carried per frame.
- PREAMBLE, 8'hAA: preamble byte, sent twice.
- SYNC_WORD, 8'h7E: frame delimiter byte.
- LEVEL_HI, 8'hFF: DAC code for bit 1.
- LEVEL_LO, 8'h00: DAC code for bit 0.
- LEVEL_IDLE, 8'h80: DAC code when not transmitting.

Ports:
- clock  input  1  single system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- sender_sync_in  input  1  transmit enable; sampled at frame boundaries.
- sender_sync_out  output  1  one-cycle pulse on the first cycle of every frame.
- sender_ad  input  8  ADC sample word, unsigned.
- sender_da  output  8  DAC output word, registered.

Behaviour:
- Reset (clock edge with reset=1):
  - sender_da=LEVEL_IDLE, sender_sync_out=0.
  - state=IDLE; sample counter, bit/cycle counters and all buffers cleared to 0.
- Input register: sender_ad is registered once every cycle (ad_q), and all captures use ad_q.
- Sampler:
  - Counter runs 0..SAMPLE_PERIOD-1 continuously out of reset, independent of state.
  - At count==SAMPLE_PERIOD-1, ad_q shifts into a PAYLOAD_BYTES-deep buffer (newest at tail, oldest dropped).
- Frame format, 8 bytes, each byte MSB-first:
  - PREAMBLE, PREAMBLE, SYNC_WORD, P0..P3, CHK.
  - P0 is the oldest buffered sample.
  - CHK = (P0+P1+P2+P3) mod 256.
  - Frame length FRAME_CYCLES = 8*8*SPB = 512 cycles.
- Snapshot: the payload buffer is copied into the frame shift register at frame start. Buffer updates during a frame do not affect that frame.
- States:
  - IDLE:
    - sender_da=LEVEL_IDLE, sync_out=0.
    - If sender_sync_in=1, go to SEND next cycle.
  - SEND, frame cycle k=0..FRAME_CYCLES-1:
    - sender_da = LEVEL_HI if frame bit floor(k/SPB) is 1, else LEVEL_LO.
    - sender_sync_out=1 only at k=0.
  - End of SEND (k=FRAME_CYCLES-1):
    - If sender_sync_in=1, the next cycle is k=0 of a new frame (back-to-back, fresh snapshot, new sync pulse).
    - Otherwise go to IDLE.
- Latency: the sync_in rising edge seen in IDLE at cycle t gives sync_out=1 and the first preamble bit on sender_da at cycle t+1.
- Deasserting sender_sync_in mid-frame has no effect; the current frame always completes.
- Reset mid-frame: the frame is aborted immediately and outputs go to reset values on the next edge.
- Arithmetic: checksum 8-bit wrap-around; counters sized to hold their maximum values without overflow.

Test Plan:
- Reset held 3 cycles, sync_in=0 -> sender_da=8'h80, sync_out=0 throughout; stays idle indefinitely with sync_in=0.
- Release reset, sync_in=1 -> sync_out pulses 1 cycle, then sender_da shows 1,0,1,0… levels (FF/00) each held 8 cycles for 16 bits, then 0x7E pattern 0,1,1,1,1,1,1,0.
- sender_ad held at 8'h20 for >4*SAMPLE_PERIOD cycles before a frame start:
  - payload bytes 20 20 20 20 and CHK=8'h80 on DAC.
  - sync_out pulses exactly every 512 cycles while sync_in=1.
- sender_ad stepping 0x20,0x21,0x22,… every 360 cycles with sync_in=1:
  - each frame's payload equals the last 4 samples captured, oldest first.
  - CHK matches the mod-256 sum, e.g. 21,21,21,22 -> 8'h85.
- sync_in dropped at k=100 -> the frame completes all 512 cycles, then sender_da=8'h80 and no further sync_out pulse.
- reset asserted at k=300 -> sender_da=8'h80 and sync_out=0 next cycle; payload buffer cleared, so the first frame after release carries CHK=0 if no sample has been captured yet.
